// File: rtl/tdm_demux_1_8.sv
// tdm_demux_1_8 -- receive end of an 8-slot TDM link.
//
// One beat per slot arrives on Data_In. A sync marker on a valid beat marks
// slot 0. A HUNT/LOCKED FSM acquires alignment and drops back to HUNT if the
// marker is missing where slot 0 is expected. Accepted beats are registered
// onto the channel selected by the slot counter, one cycle later.
//
// Ports
//   Clock_In, Reset_N_In        clock, async active-low reset
//   Enable_In                   0 = ignore inputs, hold all state
//   Data_Valid_In, Frame_Sync_In, Data_In   incoming beat and slot-0 marker
//   Data_0_Out..Data_7_Out      last beat captured per slot (held)
//   Channel_Valid_Out[7:0]      one-hot (or zero) strobe for the updated channel
//   Frame_Done_Out              pulse when slot 7 is captured
//   Slot_Out                    slot expected for the next accepted beat
//   Locked_Out                  FSM is LOCKED
//   Sync_Error_Out              pulse on an alignment violation

// Per-channel output register with its update strobe.
module tdm_demux_1_8_lane #(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  vld
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
         vld  <= 1'b0;
      end else begin
         vld <= we;
         if (we) dout <= din;
      end
   end
endmodule

module tdm_demux_1_8 #(
   parameter int DATA_WIDTH = 1
) (
   input  logic                  Clock_In,
   input  logic                  Reset_N_In,
   input  logic                  Enable_In,
   input  logic                  Data_Valid_In,
   input  logic                  Frame_Sync_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   output logic [DATA_WIDTH-1:0] Data_0_Out,
   output logic [DATA_WIDTH-1:0] Data_1_Out,
   output logic [DATA_WIDTH-1:0] Data_2_Out,
   output logic [DATA_WIDTH-1:0] Data_3_Out,
   output logic [DATA_WIDTH-1:0] Data_4_Out,
   output logic [DATA_WIDTH-1:0] Data_5_Out,
   output logic [DATA_WIDTH-1:0] Data_6_Out,
   output logic [DATA_WIDTH-1:0] Data_7_Out,
   output logic [7:0]            Channel_Valid_Out,
   output logic                  Frame_Done_Out,
   output logic [2:0]            Slot_Out,
   output logic                  Locked_Out,
   output logic                  Sync_Error_Out
);
   localparam int NUM_LANES = 8;

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [2:0] slot, slot_nxt;
   logic       cap, done_nxt, err_nxt;
   logic [2:0] cap_ch;
   logic       done_q, err_q;
   logic       accept;

   logic [NUM_LANES-1:0][DATA_WIDTH-1:0] data_q;
   logic [NUM_LANES-1:0]                 chan_vld;

   assign accept = Enable_In & Data_Valid_In;

   always_ff @(posedge Clock_In or negedge Reset_N_In) begin
      if (!Reset_N_In) begin
         state  <= HUNT;
         slot   <= '0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         slot   <= slot_nxt;
         done_q <= done_nxt;
         err_q  <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      slot_nxt  = slot;
      cap       = 1'b0;
      cap_ch    = '0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      if (accept) begin
         unique case (state)
            HUNT: begin
               // Non-marker beats are dropped silently while hunting.
               if (Frame_Sync_In) begin
                  cap       = 1'b1;
                  slot_nxt  = 3'd1;
                  state_nxt = LOCKED;
               end
            end
            LOCKED: begin
               if (slot != 3'd0) begin
                  cap = 1'b1;
                  if (Frame_Sync_In) begin
                     // Early frame start: realign on the new marker, keep lock.
                     err_nxt  = 1'b1;
                     slot_nxt = 3'd1;
                  end else begin
                     cap_ch   = slot;
                     slot_nxt = slot + 3'd1;
                     done_nxt = (slot == 3'd7);
                  end
               end else if (Frame_Sync_In) begin
                  cap      = 1'b1;
                  slot_nxt = 3'd1;
               end else begin
                  // Marker missing at slot 0: alignment lost.
                  err_nxt   = 1'b1;
                  state_nxt = HUNT;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      tdm_demux_1_8_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
         .clk   (Clock_In),
         .rst_n (Reset_N_In),
         .we    (cap && (cap_ch == 3'(k))),
         .din   (Data_In),
         .dout  (data_q[k]),
         .vld   (chan_vld[k])
      );
   end

   assign Data_0_Out        = data_q[0];
   assign Data_1_Out        = data_q[1];
   assign Data_2_Out        = data_q[2];
   assign Data_3_Out        = data_q[3];
   assign Data_4_Out        = data_q[4];
   assign Data_5_Out        = data_q[5];
   assign Data_6_Out        = data_q[6];
   assign Data_7_Out        = data_q[7];
   assign Channel_Valid_Out = chan_vld;
   assign Frame_Done_Out    = done_q;
   assign Sync_Error_Out    = err_q;
   assign Slot_Out          = slot;
   assign Locked_Out        = (state == LOCKED);
endmodule

// File: tb/tb_tdm_demux_1_8.sv
module tb_tdm_demux_1_8;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, dv, sync;
   logic [7:0] din;
   logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
   logic [7:0] cv;
   logic       done, locked, err;
   logic [2:0] slot;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [7:0] cv;
      logic [7:0] d;
      bit         done;
      bit         err;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   tdm_demux_1_8 #(.DATA_WIDTH(8)) dut (
      .Clock_In          (clk),
      .Reset_N_In        (rst_n),
      .Enable_In         (en),
      .Data_Valid_In     (dv),
      .Frame_Sync_In     (sync),
      .Data_In           (din),
      .Data_0_Out        (d0),
      .Data_1_Out        (d1),
      .Data_2_Out        (d2),
      .Data_3_Out        (d3),
      .Data_4_Out        (d4),
      .Data_5_Out        (d5),
      .Data_6_Out        (d6),
      .Data_7_Out        (d7),
      .Channel_Valid_Out (cv),
      .Frame_Done_Out    (done),
      .Slot_Out          (slot),
      .Locked_Out        (locked),
      .Sync_Error_Out    (err)
   );

   function automatic logic [7:0] dout(input int k);
      case (k)
         0: return d0;  1: return d1;  2: return d2;  3: return d3;
         4: return d4;  5: return d5;  6: return d6;  default: return d7;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: any strobe from the DUT must match the oldest expected response.
   always @(posedge clk) begin
      #1;
      if (rst_n && (cv != 8'h00 || done || err)) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: cv=0x%0h done=%0b err=%0b with nothing expected", cv, done, err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("chan_valid", cv, e.cv);
            chk("frame_done", done, e.done);
            chk("sync_error", err, e.err);
            for (int k = 0; k < 8; k++)
               if (e.cv[k]) chk($sformatf("data_%0d", k), dout(k), e.d);
         end
      end
   end

   // One cycle of stimulus; ch < 0 means no channel strobe expected.
   task automatic beat(input bit e, input bit v, input bit s, input logic [7:0] d,
                       input int ch, input bit x_done, input bit x_err);
      exp_t x;
      @(negedge clk);
      en = e; dv = v; sync = s; din = d;
      x.cv   = (ch >= 0) ? (8'h01 << ch) : 8'h00;
      x.d    = d;
      x.done = x_done;
      x.err  = x_err;
      if (x.cv != 8'h00 || x_done || x_err) sb.push_back(x);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b1, 1'b0, 1'b0, 8'h00, -1, 1'b0, 1'b0);
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 8; k++) chk($sformatf("%s_data_%0d", tag, k), dout(k), 0);
      chk({tag, "_cv"}, cv, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_slot"}, slot, 0);
      chk({tag, "_locked"}, locked, 0);
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; dv = 1'b0; sync = 1'b0; din = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Clean frame
      beat(1, 1, 1, 8'hA0, 0, 0, 0);
      chk("clean_locked_first", locked, 1);
      chk("clean_slot_first", slot, 1);
      for (int k = 1; k < 8; k++)
         beat(1, 1, 0, 8'hA0 + 8'(k), k, k == 7, 0);
      chk("clean_slot_wrap", slot, 0);
      chk("clean_locked", locked, 1);
      for (int k = 0; k < 8; k++) chk($sformatf("clean_data_%0d", k), dout(k), 8'hA0 + k);

      // Missing sync at slot 0
      beat(1, 1, 0, 8'h66, -1, 0, 1);
      chk("miss_locked", locked, 0);
      chk("miss_slot", slot, 0);
      chk("miss_data0_held", d0, 8'hA0);

      // Hunt: unmarked beats dropped, then acquire
      for (int i = 0; i < 5; i++) beat(1, 1, 0, 8'hE0 + 8'(i), -1, 0, 0);
      chk("hunt_locked_before", locked, 0);
      beat(1, 1, 1, 8'h11, 0, 0, 0);
      chk("hunt_data0", d0, 8'h11);
      chk("hunt_locked", locked, 1);
      chk("hunt_slot", slot, 1);

      // Early sync at slot 4
      beat(1, 1, 0, 8'h12, 1, 0, 0);
      beat(1, 1, 0, 8'h13, 2, 0, 0);
      beat(1, 1, 0, 8'h14, 3, 0, 0);
      chk("early_slot_before", slot, 4);
      beat(1, 1, 1, 8'h55, 0, 0, 1);
      chk("early_data0", d0, 8'h55);
      chk("early_slot", slot, 1);
      chk("early_locked", locked, 1);

      // Stall at slot 3
      beat(1, 1, 0, 8'h21, 1, 0, 0);
      beat(1, 1, 0, 8'h22, 2, 0, 0);
      for (int i = 0; i < 3; i++) begin
         beat(0, 1, 0, 8'h99, -1, 0, 0);
         chk("stall_slot", slot, 3);
      end
      chk("stall_data3_held", d3, 8'h14);
      beat(1, 1, 0, 8'h33, 3, 0, 0);
      chk("stall_data3", d3, 8'h33);
      chk("stall_slot_after", slot, 4);

      // Sync without valid is ignored
      beat(1, 0, 1, 8'h77, -1, 0, 0);
      chk("sync_novalid_slot", slot, 4);
      chk("sync_novalid_locked", locked, 1);

      // Finish frame so done pulses from mid-stream position
      beat(1, 1, 0, 8'h34, 4, 0, 0);
      beat(1, 1, 0, 8'h35, 5, 0, 0);
      beat(1, 1, 0, 8'h36, 6, 0, 0);
      beat(1, 1, 0, 8'h37, 7, 1, 0);
      chk("frame2_slot", slot, 0);

      // Mid-stream async reset
      beat(1, 1, 1, 8'h44, 0, 0, 0);
      beat(1, 1, 0, 8'h45, 1, 0, 0);
      chk("pre_reset_slot", slot, 2);
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b0; dv = 1'b0;
      idle(3);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: got %0d outstanding expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
